bram_req_master: RTL and testbench
==================================

// Module: bram_req_master
// PURPOSE
//  Initiator for the single-port synchronous RAM (cs/we/address/data_in/data_out, 1-cycle read latency).
//  Converts a valid/ready request channel into RAM port cycles.
//  Returns read data on a valid/ready response channel, buffered so consumer backpressure never loses data.
//  Sits between bus/CPU-side logic and any DATA_WIDTH x 2^ADDR_WIDTH block RAM.
// PARAMETERS
//  DATA_WIDTH  8  RAM word width
//  ADDR_WIDTH  8  RAM address width
//  RSP_DEPTH   4  response FIFO entries; power of 2, >=2; >=3 needed for 1 read/cycle throughput
// PORTS
//  clk           in   1           single clock, rising edge
//  rst_n         in   1           asynchronous active-low reset
//  req_valid     in   1           request present
//  req_ready     out  1           request accepted when req_valid && req_ready
//  req_we        in   1           1 = write, 0 = read
//  req_addr      in   ADDR_WIDTH  word address
//  req_wdata     in   DATA_WIDTH  write data
//  rsp_valid     out  1           response word available
//  rsp_ready     in   1           consumer takes response when rsp_valid && rsp_ready
//  rsp_rdata     out  DATA_WIDTH  read data (0 for write acks)
//  mem_cs        out  1           to RAM cs
//  mem_we        out  1           to RAM we
//  mem_address   out  ADDR_WIDTH  to RAM address
//  mem_data_in   out  DATA_WIDTH  to RAM data_in
//  mem_data_out  in   DATA_WIDTH  from RAM data_out
//  busy          out  1           read in flight or FIFO non-empty
// BEHAVIOUR
//  - Reset (async assert, sync release): rsp_valid=0, busy=0, FIFO count/pointers=0, rd_pending=0.
//    RAM contents untouched. A read in flight when reset asserts is discarded.
//  - RAM port is combinational from the accept:
//    mem_cs=req_valid&&req_ready, mem_we=req_we&&mem_cs, mem_address=req_addr, mem_data_in=req_wdata.
//  - req_ready = (fifo_count + rd_pending) < RSP_DEPTH.
//    Registered terms only; no combinational path from rsp_ready to req_ready.
//  - Read accepted in cycle T: rd_pending=1 in T+1; mem_data_out pushed to FIFO at end of T+1;
//    rsp_valid=1 in T+2. Fixed latency 2 with an empty FIFO.
//  - mem_data_out is sampled only in a cycle with rd_pending=1 (RAM holds data_out when cs=0).
//  - Write accepted in cycle T: RAM written at end of T.
//    Writes are posted; no response without the feature macro.
//  - Read issued in the cycle after a write to the same address returns the new data (RAM ordering).
//  - FIFO: push and pop in the same cycle leave the count unchanged, including when full.
//    Pointers wrap modulo RSP_DEPTH. rsp_rdata/rsp_valid come from the FIFO head and are stable while stalled.
//  - Responses are returned strictly in request order.
//  - busy = rd_pending || fifo_count != 0.
// CONFIGURATION
//  BRAM_MASTER_WRITE_ACK_EN
//  - defined: each accepted write also pushes a response (rsp_rdata=0) with the same 2-cycle timing
//    and the same credit rule as reads, so the requester can count completions.
//  - undefined: writes are posted, consume no FIFO credit, and are never stalled by a full FIFO
//    while req_ready is 1.
// STRUCTURE
//  - Shared header bram_defs.vh: BRAM_OP_READ=1'b0 / BRAM_OP_WRITE=1'b1 constants,
//    default DATA_WIDTH/ADDR_WIDTH.
//  - One sub-module: bram_rsp_fifo (DEPTH x DATA_WIDTH synchronous FIFO,
//    push/pop/full/empty/count, async active-low reset).
//  - Top level holds rd_pending, the credit logic and the RAM-port mux.
// TESTING (bench instantiates generic RAM model, DATA_WIDTH=8, ADDR_WIDTH=8)
//  1. Write 0xA5 @0x10, then read @0x10, rsp_ready=1
//     -> rsp_valid exactly 2 cycles after the read accept, rsp_rdata=0xA5.
//  2. Write 0x01..0x10 to 0x00..0x0F; 16 back-to-back reads, rsp_ready=1, RSP_DEPTH=4
//     -> req_ready never drops, 16 responses in order 0x01..0x10.
//  3. rsp_ready=0, issue 6 reads -> exactly 4 accepted and req_ready=0;
//     release rsp_ready -> 4 correct words, then the remaining 2 are accepted and returned.
//  4. Pulse rst_n low one cycle after a read accept
//     -> rsp_valid=0 and busy=0 immediately; no stale response after release.
//  5. Alternate write 0x3C @0xFF / read @0xFF every cycle -> every read returns 0x3C; address 0xFF works.
//  6. With BRAM_MASTER_WRITE_ACK_EN: 3 writes -> 3 responses with rsp_rdata=0.
//     Without it: 0 responses and busy stays 0.

Source files
------------

// File: rtl/bram_req_master_pkg.sv
// Shared definitions for the block-RAM request master.
//   BRAM_OP_READ / BRAM_OP_WRITE : encoding of req_we
//   BRAM_DEFAULT_*_WIDTH         : default RAM geometry
//   cnt_width()                  : width of a 0..depth occupancy counter
package bram_req_master_pkg;

  localparam logic BRAM_OP_READ  = 1'b0;
  localparam logic BRAM_OP_WRITE = 1'b1;

  localparam int unsigned BRAM_DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned BRAM_DEFAULT_ADDR_WIDTH = 8;

  // One extra bit so a full FIFO (count == depth) is representable.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// Response FIFO: DEPTH x WIDTH synchronous FIFO, head presented combinationally.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write an entry (ignored when full unless popping the same cycle)
//   pop/rdata  : rdata is the head; pop removes it (ignored when empty)
//   full/empty/count : occupancy
module bram_rsp_fifo
  import bram_req_master_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [WIDTH-1:0]              wdata,
  input  logic                          pop,
  output logic [WIDTH-1:0]              rdata,
  output logic                          full,
  output logic                          empty,
  output logic [cnt_width(DEPTH)-1:0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = cnt_width(DEPTH);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A pop frees the slot this push needs, so push+pop on a full FIFO is legal.
    do_push  = push && ((count_q != FullCnt) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_comb begin
    rdata = mem_q[rd_ptr_q];
    full  = (count_q == FullCnt);
    empty = (count_q == '0);
    count = count_q;
  end

endmodule

// File: rtl/bram_req_master.sv
// Initiator for a single-port synchronous RAM (1-cycle read latency).
// Turns a valid/ready request channel into RAM cycles and returns read data on a
// valid/ready response channel through a credit-managed FIFO, so consumer
// backpressure never drops a word.
//   req_*  : request channel (req_we: 1 = write, 0 = read)
//   rsp_*  : response channel (rsp_rdata = 0 for write acks)
//   mem_*  : RAM port (cs/we/address/data_in driven, data_out sampled)
//   busy   : response in flight or FIFO non-empty
// Build option: define BRAM_MASTER_WRITE_ACK_EN to return a zero-data response for
// every accepted write; otherwise writes are posted and take no FIFO credit.
module bram_req_master
  import bram_req_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = BRAM_DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = BRAM_DEFAULT_ADDR_WIDTH,
  parameter int unsigned RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  busy
);

  localparam int unsigned CntW = cnt_width(RSP_DEPTH);
  localparam logic [CntW:0] CreditMax = (CntW + 1)'(RSP_DEPTH);

`ifdef BRAM_MASTER_WRITE_ACK_EN
  localparam bit WriteAck = 1'b1;
`else
  localparam bit WriteAck = 1'b0;
`endif

  logic                  accept;
  logic                  rd_pending_q, rd_pending_d;
  logic                  ack_pending_q, ack_pending_d;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_wdata;
  logic [CntW-1:0]       fifo_count;
  logic [CntW:0]         credit_used;

  always_comb begin
    // Credit from registered state only: no rsp_ready -> req_ready path.
    credit_used = {1'b0, fifo_count} + {{CntW{1'b0}}, rd_pending_q};
    req_ready   = !fifo_full && (credit_used < CreditMax);
    accept      = req_valid && req_ready;

    mem_cs      = accept;
    mem_we      = accept && (req_we == BRAM_OP_WRITE);
    mem_address = req_addr;
    mem_data_in = req_wdata;

    // rd_pending marks "a response is due next cycle"; with write acks it covers writes too.
    rd_pending_d  = accept && ((req_we == BRAM_OP_READ) || WriteAck);
    ack_pending_d = accept && (req_we == BRAM_OP_WRITE);

    // RAM holds data_out while cs=0, so it is only captured on the pending cycle.
    fifo_push  = rd_pending_q;
    fifo_wdata = ack_pending_q ? '0 : mem_data_out;

    rsp_valid  = !fifo_empty;
    fifo_pop   = rsp_valid && rsp_ready;
    busy       = rd_pending_q || !fifo_empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending_q  <= 1'b0;
      ack_pending_q <= 1'b0;
    end else begin
      rd_pending_q  <= rd_pending_d;
      ack_pending_q <= ack_pending_d;
    end
  end

  bram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (rsp_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_bram_req_master.sv
// Bench for bram_req_master with an 8x256 generic synchronous RAM model.
// The reference model tracks RAM contents and a queue of expected responses,
// each due two cycles after its accept; credit = responses accepted but not consumed.
module tb_bram_req_master;

  localparam int Depth = 4;
`ifdef BRAM_MASTER_WRITE_ACK_EN
  localparam bit AckEn = 1'b1;
`else
  localparam bit AckEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic       req_ready, rsp_valid, mem_cs, mem_we, busy;
  logic [7:0] rsp_rdata, mem_address, mem_data_in, mem_data_out;

  always #5 clk = ~clk;

  bram_req_master #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (8),
    .RSP_DEPTH  (Depth)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .mem_cs       (mem_cs),
    .mem_we       (mem_we),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .busy         (busy)
  );

  // Generic single-port RAM: 1-cycle read latency, data_out held when cs=0.
  logic [7:0] ram [256];
  logic [7:0] ram_dout;
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) ram[mem_address] <= mem_data_in;
      else        ram_dout <= ram[mem_address];
    end
  end
  assign mem_data_out = ram_dout;

  typedef struct {
    int unsigned due;
    logic [7:0]  data;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  ref_mem [256];
  int unsigned cyc = 0;
  int          n_checks = 0, n_fail = 0;
  logic        obs_ready, obs_valid, obs_busy, exp_ready, exp_valid, exp_busy, acc, popped;
  logic [7:0]  obs_rdata, exp_rdata;

  // One bus cycle: drive at negedge, sample 1 ns later, then advance the model.
  task automatic step(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d,
                      input logic rr);
    @(negedge clk);
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; rsp_ready = rr;
    #1;
    exp_ready = exp_q.size() < Depth;
    exp_valid = (exp_q.size() != 0) && (exp_q[0].due <= cyc);
    exp_rdata = exp_valid ? exp_q[0].data : 8'h00;
    exp_busy  = exp_q.size() != 0;
    obs_ready = req_ready; obs_valid = rsp_valid; obs_rdata = rsp_rdata; obs_busy = busy;
    acc    = v && obs_ready;
    popped = obs_valid && rr;
    if (popped && exp_q.size() != 0) void'(exp_q.pop_front());
    if (acc) begin
      if (we) begin
        ref_mem[a] = d;
        if (AckEn) exp_q.push_back('{cyc + 2, 8'h00});
      end else begin
        exp_q.push_back('{cyc + 2, ref_mem[a]});
      end
    end
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      n++;
    end
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d responses still owed, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks += 3;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_rw();
    int lat = -1;
    logic [7:0] got = 8'h00;
    step(1'b1, 1'b1, 8'h10, 8'hA5, 1'b1);
    step(1'b1, 1'b0, 8'h10, 8'h00, 1'b1);
    n_checks++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL single_read_accept: got %b want 1", acc); end
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      if (obs_valid && lat < 0) begin lat = k; got = obs_rdata; end
    end
    n_checks += 2;
    if (lat != 2)     begin n_fail++; $display("FAIL single_latency: got %0d want 2", lat); end
    if (got !== 8'hA5) begin n_fail++; $display("FAIL single_rdata: got %h want a5", got); end
    drain();
  endtask

  task automatic test_back_to_back();
    int pops = 0, n = 0;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 8'(i), 8'(i + 1), 1'b1);
    drain();
    for (int i = 0; i < 16 || (exp_q.size() != 0 && n < 30); i++) begin
      if (i < 16) step(1'b1, 1'b0, 8'(i), 8'h00, 1'b1);
      else begin step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1); n++; end
      if (i < 16) begin
        n_checks++;
        if (obs_ready !== 1'b1) begin
          n_fail++; $display("FAIL b2b_req_ready cycle %0d: got %b want 1", i, obs_ready);
        end
      end
      n_checks++;
      if (obs_valid !== exp_valid) begin
        n_fail++; $display("FAIL b2b_rsp_valid cycle %0d: got %b want %b", i, obs_valid, exp_valid);
      end
      if (popped) begin
        n_checks++;
        if (obs_rdata !== 8'(pops + 1)) begin
          n_fail++; $display("FAIL b2b_order #%0d: got %h want %h", pops, obs_rdata, 8'(pops + 1));
        end
        pops++;
      end
    end
    n_checks++;
    if (pops != 16) begin n_fail++; $display("FAIL b2b_count: got %0d want 16", pops); end
    drain();
  endtask

  task automatic test_backpressure();
    int issued = 0, pops = 0, n = 0;
    for (int k = 0; k < 10; k++) begin
      step(issued < 6, 1'b0, 8'(issued), 8'h00, 1'b0);
      if (acc) issued++;
    end
    n_checks += 2;
    if (issued != 4)        begin n_fail++; $display("FAIL bp_accepted: got %0d want 4", issued); end
    if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready: got %b want 0", obs_ready); end
    while ((issued < 6 || pops < 6) && n < 40) begin
      step(issued < 6, 1'b0, 8'(issued), 8'h00, 1'b1);
      if (acc) issued++;
      if (popped) begin
        n_checks++;
        if (obs_rdata !== 8'(pops + 1) || obs_rdata !== exp_rdata) begin
          n_fail++; $display("FAIL bp_rdata #%0d: got %h want %h", pops, obs_rdata, 8'(pops + 1));
        end
        pops++;
      end
      n++;
    end
    n_checks++;
    if (pops != 6) begin n_fail++; $display("FAIL bp_returned: got %0d want 6", pops); end
    drain();
  endtask

  task automatic test_reset_inflight();
    step(1'b1, 1'b0, 8'h03, 8'h00, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks += 2;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_inflight_valid: got %b want 0", rsp_valid); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_inflight_busy: got %b want 0", busy); end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      n_checks++;
      if (obs_valid !== 1'b0 || obs_busy !== 1'b0) begin
        n_fail++; $display("FAIL rst_stale cycle %0d: valid=%b busy=%b want 0/0", k, obs_valid, obs_busy);
      end
    end
  endtask

  task automatic test_alternate();
    int hits = 0;
    step(1'b1, 1'b1, 8'hFF, 8'h11, 1'b1);
    drain();
    for (int i = 0; i < 24; i++) begin
      if (i < 20) step(1'b1, !i[0], 8'hFF, 8'h3C, 1'b1);
      else        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      n_checks++;
      if (obs_valid !== exp_valid || (exp_valid && obs_rdata !== exp_rdata)) begin
        n_fail++;
        $display("FAIL alt_rsp cycle %0d: valid=%b data=%h want %b/%h", i, obs_valid, obs_rdata,
                 exp_valid, exp_rdata);
      end
      if (popped && obs_rdata === 8'h3C) hits++;
    end
    n_checks++;
    if (hits != 10) begin n_fail++; $display("FAIL alt_reads: got %0d words of 3c want 10", hits); end
    drain();
  endtask

  task automatic test_write_ack();
    int pops = 0;
    for (int i = 0; i < 9; i++) begin
      step(i < 3, 1'b1, 8'(8'h20 + i), 8'($urandom), 1'b1);
      n_checks++;
      if (obs_busy !== exp_busy) begin
        n_fail++; $display("FAIL wack_busy cycle %0d: got %b want %b", i, obs_busy, exp_busy);
      end
      if (popped) begin
        pops++;
        n_checks++;
        if (obs_rdata !== 8'h00) begin n_fail++; $display("FAIL wack_rdata: got %h want 00", obs_rdata); end
      end
    end
    n_checks++;
    if (pops != (AckEn ? 3 : 0)) begin
      n_fail++; $display("FAIL wack_count: got %0d want %0d", pops, AckEn ? 3 : 0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(($urandom % 4) != 0, 1'($urandom), 8'($urandom % 16), 8'($urandom), ($urandom % 3) != 0);
      n_checks += 4;
      if (obs_ready !== exp_ready) begin
        n_fail++; $display("FAIL rand_req_ready cycle %0d: got %b want %b", i, obs_ready, exp_ready);
      end
      if (obs_valid !== exp_valid) begin
        n_fail++; $display("FAIL rand_rsp_valid cycle %0d: got %b want %b", i, obs_valid, exp_valid);
      end
      if (obs_busy !== exp_busy) begin
        n_fail++; $display("FAIL rand_busy cycle %0d: got %b want %b", i, obs_busy, exp_busy);
      end
      if (exp_valid && obs_rdata !== exp_rdata) begin
        n_fail++; $display("FAIL rand_rdata cycle %0d: got %h want %h", i, obs_rdata, exp_rdata);
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_rw();
    test_back_to_back();
    test_backpressure();
    test_reset_inflight();
    test_alternate();
    test_write_ack();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
